// File: rtl/input_sel_sequencer_pkg.sv
// input_sel_pkg: shared types and constants for the input-type selection sequencer.
//   state_e   - debounce FSM states
//   dir_e     - step direction (DIR_NEXT / DIR_PREV)
//   NUM_SEL   - number of selectable input types
//   step_sel  - apply one step to a selection value, wrapping modulo NUM_SEL
package input_sel_pkg;

    localparam int unsigned NUM_SEL = 4;
    localparam int unsigned SelW    = $clog2(NUM_SEL);

    typedef logic [SelW-1:0] sel_t;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StHeld,
        StRelease
    } state_e;

    typedef enum logic {
        DIR_NEXT,
        DIR_PREV
    } dir_e;

    // NUM_SEL is a power of two, so plain wrap-around of sel_t is the modulo.
    function automatic sel_t step_sel(input sel_t cur, input dir_e dir);
        return (dir == DIR_NEXT) ? sel_t'(cur + 1'b1) : sel_t'(cur - 1'b1);
    endfunction

endpackage

// File: rtl/input_sel_sequencer_if.sv
// input_sel_sequencer_if: button inputs and selection outputs of the sequencer.
//   next, prev  - raw active-low pushbuttons (step forward / backward)
//   lock        - datapath busy, defers selection changes
//   sel         - current selection
//   sel_changed - one-cycle pulse when sel takes a new value
//   pending     - a step is waiting for lock to drop
//   drop_err    - one-cycle pulse when an accepted step is discarded
// master: drives buttons/lock (board or bench); slave: the sequencer.
interface input_sel_sequencer_if;
    import input_sel_pkg::*;

    logic next;
    logic prev;
    logic lock;
    sel_t sel;
    logic sel_changed;
    logic pending;
    logic drop_err;

    modport master (
        output next, prev, lock,
        input  sel, sel_changed, pending, drop_err
    );

    modport slave (
        input  next, prev, lock,
        output sel, sel_changed, pending, drop_err
    );

endinterface

// File: rtl/input_sel_sequencer_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle enable every TICK_DIV clocks.
//   clk_10MHz - clock
//   reset     - synchronous active-low reset (counter cleared to 0)
//   tick      - high in the cycle the counter sits at TICK_DIV-1 (wrap)
module tick_gen #(
    parameter int unsigned TICK_DIV = 24'h080000
) (
    input  logic clk_10MHz,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_10MHz) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/input_sel_sequencer.sv
// input_sel_sequencer: debounces next/prev pushbuttons and steps a 2-bit selection,
// deferring one step while the datapath is locked.
//   clk_10MHz - clock
//   reset     - synchronous active-low reset
//   bus       - input_sel_sequencer_if slave (buttons, lock, sel and status pulses)
module input_sel_sequencer
    import input_sel_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 24'h080000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input logic                  clk_10MHz,
    input logic                  reset,
    input_sel_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_TICKS);

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_10MHz (clk_10MHz),
        .reset     (reset),
        .tick      (tick)
    );

    // Two-flop synchronizers; reset value 1 = button released.
    logic [1:0] next_sync_q, next_sync_d;
    logic [1:0] prev_sync_q, prev_sync_d;
    logic       btn_next, btn_prev;

    assign next_sync_d = {next_sync_q[0], bus.next};
    assign prev_sync_d = {prev_sync_q[0], bus.prev};
    assign btn_next    = ~next_sync_q[1];
    assign btn_prev    = ~prev_sync_q[1];

    // Debounce FSM
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    dir_e            dir_q, dir_d;
    logic            latched_on;
    logic            any_on;
    logic            step_valid;

    assign cnt_inc    = cnt_q + 1'b1;
    assign latched_on = (dir_q == DIR_NEXT) ? btn_next : btn_prev;
    assign any_on     = btn_next | btn_prev;

    always_ff @(posedge clk_10MHz) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dir_q       <= DIR_NEXT;
            next_sync_q <= 2'b11;
            prev_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            next_sync_q <= next_sync_d;
            prev_sync_q <= prev_sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    // Both buttons at once is ambiguous and ignored.
                    if (btn_next ^ btn_prev) begin
                        state_d = StPress;
                        cnt_d   = '0;
                        dir_d   = btn_next ? DIR_NEXT : DIR_PREV;
                    end
                end
                StPress: begin
                    if (latched_on) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) state_d = StHeld;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (!any_on) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end
                end
                StRelease: begin
                    if (any_on) begin
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        step_valid = tick && (state_q == StPress) && latched_on && (cnt_inc == DebMax);
    end

    // Selection / deferral
    sel_t sel_q, sel_d;
    logic sel_changed_q, sel_changed_d;
    logic pending_q, pending_d;
    dir_e pend_dir_q, pend_dir_d;
    logic drop_err_q, drop_err_d;

    always_comb begin
        sel_d         = sel_q;
        sel_changed_d = 1'b0;
        pending_d     = pending_q;
        pend_dir_d    = pend_dir_q;
        drop_err_d    = 1'b0;
        if (pending_q && !bus.lock) begin
            // Deferred step goes first; a coinciding new step takes the freed slot.
            sel_d         = step_sel(sel_q, pend_dir_q);
            sel_changed_d = 1'b1;
            pending_d     = step_valid;
            if (step_valid) pend_dir_d = dir_q;
        end else if (step_valid) begin
            if (pending_q) begin
                drop_err_d = 1'b1;
            end else if (bus.lock) begin
                pending_d  = 1'b1;
                pend_dir_d = dir_q;
            end else begin
                sel_d         = step_sel(sel_q, dir_q);
                sel_changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10MHz) begin
        if (!reset) begin
            sel_q         <= '0;
            sel_changed_q <= 1'b0;
            pending_q     <= 1'b0;
            pend_dir_q    <= DIR_NEXT;
            drop_err_q    <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            sel_changed_q <= sel_changed_d;
            pending_q     <= pending_d;
            pend_dir_q    <= pend_dir_d;
            drop_err_q    <= drop_err_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sel_changed = sel_changed_q;
    assign bus.pending     = pending_q;
    assign bus.drop_err    = drop_err_q;

endmodule

// File: tb/tb_input_sel_sequencer.sv
// Bench for input_sel_sequencer with TICK_DIV=4, DEBOUNCE_TICKS=2: directed button
// scenarios, a behavioural model checked every cycle, and literal end-of-scenario checks.
module tb_input_sel_sequencer;
    import input_sel_pkg::*;

    localparam int TickDiv = 4;
    localparam int Deb     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    input_sel_sequencer_if bus ();

    input_sel_sequencer #(
        .TICK_DIV       (TickDiv),
        .DEBOUNCE_TICKS (Deb)
    ) dut (
        .clk_10MHz (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: sync delay as a two-deep history, tick as edge count modulo
    // TickDiv, debounce as run lengths of qualifying ticks, selection by mod-4 arithmetic.
    bit m_valid = 0;
    bit m_s1n, m_s2n, m_s1p, m_s2p;
    int m_edges;
    bit m_armed;
    int m_press_run;
    int m_quiet;
    int m_dir;
    int exp_sel, exp_chg, exp_pend, exp_pdir, exp_drop;

    function automatic int apply_dir(input int s, input int d);
        return (s + ((d == 0) ? 1 : NUM_SEL - 1)) % NUM_SEL;
    endfunction

    task automatic model_step();
        bit bn, bp, tk, step;
        if (!rst_n) begin
            m_valid = 1; m_s1n = 1; m_s2n = 1; m_s1p = 1; m_s2p = 1;
            m_edges = 0; m_armed = 1; m_press_run = 0; m_quiet = 0; m_dir = 0;
            exp_sel = 0; exp_chg = 0; exp_pend = 0; exp_pdir = 0; exp_drop = 0;
            return;
        end
        bn = !m_s2n;
        bp = !m_s2p;
        tk = (m_edges % TickDiv) == TickDiv - 1;
        m_edges++;
        m_s2n = m_s1n; m_s1n = bus.next;
        m_s2p = m_s1p; m_s1p = bus.prev;
        step = 0;
        if (tk) begin
            if (m_armed) begin
                if (m_press_run == 0) begin
                    if (bn != bp) begin
                        m_press_run = 1;
                        m_dir = bn ? 0 : 1;
                    end
                end else if ((m_dir == 0) ? bn : bp) begin
                    m_press_run++;
                    // Accepted once the button is seen on Deb ticks after the first one.
                    if (m_press_run == Deb + 1) begin
                        step = 1; m_armed = 0; m_quiet = 0; m_press_run = 0;
                    end
                end else begin
                    m_press_run = 0;
                end
            end else begin
                if (bn || bp) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == Deb + 1) m_armed = 1;
                end
            end
        end
        exp_chg = 0;
        exp_drop = 0;
        if (exp_pend != 0 && !bus.lock) begin
            exp_sel = apply_dir(exp_sel, exp_pdir);
            exp_chg = 1;
            exp_pend = step;
            if (step) exp_pdir = m_dir;
        end else if (step) begin
            if (exp_pend != 0) exp_drop = 1;
            else if (bus.lock) begin
                exp_pend = 1; exp_pdir = m_dir;
            end else begin
                exp_sel = apply_dir(exp_sel, m_dir);
                exp_chg = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    int chg_cnt = 0;
    int drop_cnt = 0;
    int b2b_cnt = 0;
    bit last_chg = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_sel", int'(bus.sel), exp_sel);
                check("model_sel_changed", int'(bus.sel_changed), exp_chg);
                check("model_pending", int'(bus.pending), exp_pend);
                check("model_drop_err", int'(bus.drop_err), exp_drop);
                if (bus.sel_changed) chg_cnt++;
                if (bus.drop_err) drop_cnt++;
                if (bus.sel_changed && last_chg) b2b_cnt++;
                last_chg = bus.sel_changed;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit is_next, input int low, input int high);
        if (is_next) bus.next = 1'b0;
        else bus.prev = 1'b0;
        idle(low);
        bus.next = 1'b1;
        bus.prev = 1'b1;
        idle(high);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int base;
    int exp_seq[4] = '{0, 1, 2, 3};

    initial begin
        bus.next = 1'b1;
        bus.prev = 1'b1;
        bus.lock = 1'b0;
        idle(3);
        check("reset_sel", int'(bus.sel), 0);
        check("reset_sel_changed", int'(bus.sel_changed), 0);
        check("reset_pending", int'(bus.pending), 0);
        check("reset_drop_err", int'(bus.drop_err), 0);
        rst_n = 1'b1;
        idle(2);

        // Long hold then release: exactly one step.
        base = chg_cnt;
        press(1, 40, 40);
        check("hold_one_step_sel", int'(bus.sel), 1);
        check("hold_one_step_pulses", chg_cnt - base, 1);

        // prev wraps 0 -> 3, then next walks 0,1,2,3.
        do_reset();
        press(0, 40, 40);
        check("prev_wrap_sel", int'(bus.sel), 3);
        for (int i = 0; i < 4; i++) begin
            press(1, 40, 40);
            check("next_walk_sel", int'(bus.sel), exp_seq[i]);
        end

        // Glitch shorter than the debounce window.
        do_reset();
        base = chg_cnt;
        press(1, 5, 40);
        check("short_glitch_sel", int'(bus.sel), 0);
        check("short_glitch_pulses", chg_cnt - base, 0);

        // Both buttons together are ignored.
        do_reset();
        base = chg_cnt;
        bus.next = 1'b0;
        press(0, 40, 40);
        check("both_pressed_sel", int'(bus.sel), 0);
        check("both_pressed_pulses", chg_cnt - base, 0);

        // Deferred step applied when lock drops.
        do_reset();
        bus.lock = 1'b1;
        press(1, 40, 40);
        check("locked_pending", int'(bus.pending), 1);
        check("locked_sel", int'(bus.sel), 0);
        bus.lock = 1'b0;
        idle(1);
        check("unlock_sel", int'(bus.sel), 1);
        check("unlock_pending", int'(bus.pending), 0);
        check("unlock_pulse", int'(bus.sel_changed), 1);

        // Second step while pending is dropped.
        do_reset();
        base = drop_cnt;
        bus.lock = 1'b1;
        press(1, 40, 40);
        press(1, 40, 40);
        check("drop_pulses", drop_cnt - base, 1);
        check("drop_keeps_pending", int'(bus.pending), 1);
        bus.lock = 1'b0;
        idle(20);
        check("drop_final_sel", int'(bus.sel), 1);

        // Reset discards a pending step.
        do_reset();
        bus.lock = 1'b1;
        press(1, 40, 40);
        check("pre_reset_pending", int'(bus.pending), 1);
        do_reset();
        check("post_reset_sel", int'(bus.sel), 0);
        check("post_reset_pending", int'(bus.pending), 0);
        base = chg_cnt;
        bus.lock = 1'b0;
        idle(20);
        check("post_reset_no_change", chg_cnt - base, 0);

        // Sweep the lock release across the acceptance of a second step.
        base = b2b_cnt;
        for (int off = 0; off < 16; off++) begin
            do_reset();
            bus.lock = 1'b1;
            press(1, 40, 40);
            bus.next = 1'b0;
            idle(off);
            bus.lock = 1'b0;
            idle(40 - off);
            bus.next = 1'b1;
            idle(40);
        end
        check("coincide_back_to_back_seen", int'(b2b_cnt > base), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_sel_sequencer.md
INPUT_SEL_SEQUENCER -- requirements
Module: input_sel_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 24'h080000, meaning clk_10MHz cycles per debounce tick.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, meaning consecutive stable ticks needed to accept a press or release.
REQ-003 SHALL have port clk_10MHz, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port next, input, 1 bit: raw asynchronous pushbutton, active-low, step forward.
REQ-006 SHALL have port prev, input, 1 bit: raw asynchronous pushbutton, active-low, step backward.
REQ-007 SHALL have port lock, input, 1 bit: datapath busy; selection changes are deferred while it is high.
REQ-008 SHALL have port sel, output, 2 bits: current input-type selection driving the display/datapath.
REQ-009 SHALL have port sel_changed, output, 1 bit: one-cycle pulse in the cycle sel takes a new value.
REQ-010 SHALL have port pending, output, 1 bit: high while an accepted step is deferred by lock.
REQ-011 SHALL have port drop_err, output, 1 bit: one-cycle pulse when an accepted step is discarded.

Function
REQ-012 All logic SHALL run on clk_10MHz; no derived clocks; tick is a 1-cycle enable every TICK_DIV cycles (counter 0..TICK_DIV-1, tick on wrap).
REQ-013 next and prev SHALL each pass a 2-flop synchronizer and be inverted to active-high before use.
REQ-014 FSM states: IDLE, PRESS, HELD, RELEASE; all transitions on tick only.
REQ-015 IDLE: exactly one synchronized button asserted -> PRESS, latch direction, clear stable count; both or neither -> stay IDLE.
REQ-016 PRESS: latched button still asserted -> increment count; at DEBOUNCE_TICKS -> accept step, go HELD; released earlier -> IDLE, no step.
REQ-017 HELD: wait for both buttons deasserted -> RELEASE, clear count; holding never produces repeat steps.
REQ-018 RELEASE: both deasserted for DEBOUNCE_TICKS ticks -> IDLE; any assertion -> back to HELD.
REQ-019 Step arithmetic: next = sel+1 mod 4 (3 -> 0), prev = sel-1 mod 4 (0 -> 3).
REQ-020 Accepted step with lock=0 and no pending: sel updates on the next clock edge; sel_changed pulses that cycle.
REQ-021 Accepted step with lock=1: stored in the single pending slot; pending goes high; sel unchanged.
REQ-022 Accepted step while pending is already set: discarded; drop_err pulses one cycle; stored step kept.
REQ-023 Pending step and lock=0: applied on the next edge, pending clears, sel_changed pulses.
REQ-024 Pending application coinciding with a newly accepted step: apply pending; new step becomes pending, applied the following cycle if lock stays 0; no drop.
REQ-025 sel_changed SHALL never be high two consecutive cycles except under REQ-024.

Reset
REQ-026 With reset=0 at a clock edge: sel=0, sel_changed=0, pending=0, drop_err=0, FSM=IDLE, tick counter=0, synchronizers=released.
REQ-027 Reset mid-debounce or with pending set SHALL discard all in-progress and deferred steps.

Structure
REQ-028 Package input_sel_pkg SHALL hold the FSM state enum, a step-direction typedef (DIR_NEXT, DIR_PREV), and constant NUM_SEL=4.
REQ-029 Tick generation SHALL be one sub-module, tick_gen (parameter TICK_DIV; outputs tick).

Verification (TICK_DIV=4, DEBOUNCE_TICKS=2)
REQ-030 Hold next low 40 cycles, release 40 -> sel 0->1, exactly one sel_changed.
REQ-031 From reset, prev pressed/released cleanly -> sel=3; four next presses from 3 -> sequence 0,1,2,3.
REQ-032 next low for 5 cycles (shorter than 2 ticks) -> no sel_changed, sel stays 0.
REQ-033 lock=1, one next press -> pending=1, sel=0; drop lock -> sel=1 the next cycle, pending=0.
REQ-034 lock=1, two next presses -> second press pulses drop_err once; drop lock -> sel=1 only.
REQ-035 pending=1, then reset=0 for one cycle -> sel=0, pending=0; releasing lock afterwards produces no sel_changed.
